// File: rtl/serial_parity_checker.sv
// Serial LSB-first frame receiver: deserialises DATA_W data bits plus a trailing
// parity bit, checks XOR parity and keeps a saturating count of bad/aborted frames.
module serial_parity_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_ok,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int            CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic          ODD_B     = (ODD != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_par;
  logic [DATA_W-1:0]   r_word;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_par_ok;
  logic [CNT_W-1:0]    r_err;

  logic                w_start;
  logic                w_data_bit;
  logic                w_abort;
  logic                w_par_done;
  logic                w_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_start = in_valid && in_sof;
  assign w_ok    = (in_bit == (r_par ^ ODD_B));

  always_comb begin
    w_state_nxt = r_state;
    w_data_bit  = 1'b0;
    w_abort     = 1'b0;
    w_par_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_start) begin
          w_abort = 1'b1;
        end else if (in_valid) begin
          w_data_bit = 1'b1;
          if (r_cnt == LAST_DATA) w_state_nxt = S_PAR;
        end
      end
      S_PAR: begin
        if (w_start) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DATA;
        end else if (in_valid) begin
          w_par_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bits shift in at the MSB so the first (LSB) bit reaches bit 0 once the word is
  // complete; the partial word stays internal until the parity bit is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_word       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_par_ok <= 1'b0;
      r_err        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_par_done;
      if (w_start) begin
        r_word <= {in_bit, r_word[DATA_W-1:1]};
        r_par  <= in_bit;
        r_cnt  <= CW'(1);
      end else if (w_data_bit) begin
        r_word <= {in_bit, r_word[DATA_W-1:1]};
        r_par  <= r_par ^ in_bit;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_par_done) begin
        r_out_data   <= r_word;
        r_out_par_ok <= w_ok;
      end
      if (w_abort || (w_par_done && !w_ok)) r_err <= sat_inc(r_err);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_par_ok = r_out_par_ok;
  assign err_count  = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even/8-bit, odd/8-bit and even/2-bit-counter
// instances share one stimulus stream and are compared against a frame-level model.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_sof;

  logic       d_valid, d_ok, d_busy;
  logic [7:0] d_data, d_err;
  logic       o_valid, o_ok, o_busy;
  logic [7:0] o_data, o_err;
  logic       s_valid, s_ok, s_busy;
  logic [7:0] s_data;
  logic [1:0] s_err;

  int nchk = 0;
  int nerr = 0;
  int npulse = 0;

  // model state
  bit         m_in_frame = 0;
  bit         m_q[$];
  logic       m_valid = 0, m_ok_e = 0, m_ok_o = 0, m_busy = 0;
  logic [7:0] m_data = 0;
  int         m_err_e = 0, m_err_o = 0, m_err_s = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(d_valid), .out_data(d_data), .out_par_ok(d_ok), .err_count(d_err), .busy(d_busy));

  serial_parity_checker #(.DATA_W(8), .ODD(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(o_valid), .out_data(o_data), .out_par_ok(o_ok), .err_count(o_err), .busy(o_busy));

  serial_parity_checker #(.DATA_W(8), .ODD(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(s_valid), .out_data(s_data), .out_par_ok(s_ok), .err_count(s_err), .busy(s_busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  // Frame-level model: a frame is the sof bit plus the following accepted bits.
  task automatic mdl(input logic r, input logic v, input logic s, input logic b);
    int ones;
    if (r) begin
      m_in_frame = 0; m_q.delete();
      m_valid = 0; m_data = 0; m_ok_e = 0; m_ok_o = 0;
      m_err_e = 0; m_err_o = 0; m_err_s = 0;
    end else begin
      m_valid = 0;
      if (v) begin
        if (s) begin
          if (m_in_frame) begin
            m_err_e = sat(m_err_e, 255); m_err_o = sat(m_err_o, 255); m_err_s = sat(m_err_s, 3);
          end
          m_q.delete(); m_q.push_back(b); m_in_frame = 1;
        end else if (m_in_frame) begin
          if (m_q.size() < 8) m_q.push_back(b);
          else begin
            m_data = 0; ones = 0;
            for (int i = 0; i < 8; i++) begin
              m_data = m_data + (8'(m_q[i]) << i);
              ones += int'(m_q[i]);
            end
            m_ok_e = (b == ((ones % 2) == 1));
            m_ok_o = (b == ((ones % 2) == 0));
            if (!m_ok_e) begin
              m_err_e = sat(m_err_e, 255); m_err_s = sat(m_err_s, 3);
            end
            if (!m_ok_o) m_err_o = sat(m_err_o, 255);
            m_valid = 1; m_in_frame = 0; m_q.delete();
          end
        end
      end
    end
    m_busy = m_in_frame;
  endtask

  task automatic check_all();
    chk("valid", d_valid, m_valid);
    chk("data", d_data, m_data);
    chk("ok", d_ok, m_ok_e);
    chk("err", d_err, 32'(m_err_e));
    chk("busy", d_busy, m_busy);
    chk("odd_valid", o_valid, m_valid);
    chk("odd_data", o_data, m_data);
    chk("odd_ok", o_ok, m_ok_o);
    chk("odd_err", o_err, 32'(m_err_o));
    chk("sat_valid", s_valid, m_valid);
    chk("sat_ok", s_ok, m_ok_e);
    chk("sat_err", s_err, 32'(m_err_s));
  endtask

  task automatic cyc(input logic r, input logic v, input logic s, input logic b);
    rst = r; in_valid = v; in_sof = s; in_bit = b;
    @(posedge clk);
    mdl(r, v, s, b);
    #1;
    check_all();
    if (d_valid) npulse++;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, (i == 0), w[i]);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b1, 1'b0, p);
  endtask

  typedef struct {
    logic v, s, b;
    logic ev; logic [7:0] ed; logic eok; logic [7:0] eerr; logic ebusy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] a5;
    int p0, e0;
    int sat_exp[5];
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;
    a5 = 8'hA5;
    sat_exp = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{v:1'b1, s:(i == 0), b:a5[i], ev:1'b0, ed:8'h00, eok:1'b0, eerr:8'd0, ebusy:1'b1};
    tbl[8] = '{v:1'b1, s:1'b0, b:1'b0, ev:1'b1, ed:8'hA5, eok:1'b1, eerr:8'd0, ebusy:1'b0};
    tbl[9] = '{v:1'b0, s:1'b0, b:1'b0, ev:1'b0, ed:8'hA5, eok:1'b1, eerr:8'd0, ebusy:1'b0};

    // reset state
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", d_valid, 0); chk("rst_data", d_data, 0); chk("rst_ok", d_ok, 0);
    chk("rst_err", d_err, 0); chk("rst_busy", d_busy, 0);

    // good 0xA5 frame, table driven
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, tbl[i].v, tbl[i].s, tbl[i].b);
      chk("t1_valid", d_valid, tbl[i].ev); chk("t1_data", d_data, tbl[i].ed);
      chk("t1_ok", d_ok, tbl[i].eok); chk("t1_err", d_err, tbl[i].eerr);
      chk("t1_busy", d_busy, tbl[i].ebusy);
    end

    // bad parity on even, good on odd
    send_frame(8'hA5, 1'b1, 0);
    chk("t2_valid", d_valid, 1); chk("t2_ok", d_ok, 0); chk("t2_err", d_err, 1);
    chk("t2_odd_ok", o_ok, 1);

    // gaps and non-sof bits while idle
    cyc(1'b0, 1'b1, 1'b0, 1'b1); cyc(1'b0, 1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3_idle_busy", d_busy, 0);
    p0 = npulse;
    send_frame(8'h3C, 1'b0, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pulses", npulse - p0, 1); chk("t3_data", d_data, 8'h3C); chk("t3_ok", d_ok, 1);

    // abort then full 0x81 frame
    e0 = int'(d_err); p0 = npulse;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'(i & 1));
    send_frame(8'h81, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_err", d_err, 32'(e0 + 1)); chk("t4_pulses", npulse - p0, 1);
    chk("t4_data", d_data, 8'h81); chk("t4_ok", d_ok, 1);

    // saturation with back-to-back frames (sof lands in the out_valid cycle)
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b1, 0);
      chk("t5_sat_err", s_err, 32'(sat_exp[k]));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_err8", d_err, 5);

    // reset mid-frame
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_valid", d_valid, 0); chk("t6_data", d_data, 0); chk("t6_ok", d_ok, 0);
    chk("t6_err", d_err, 0); chk("t6_busy", d_busy, 0);
    send_frame(8'hFF, 1'b0, 0);
    chk("t6_ff_data", d_data, 8'hFF); chk("t6_ff_ok", d_ok, 1); chk("t6_ff_valid", d_valid, 1);

    // random stream against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
